seven_seg_scan: RTL
===================

// Module: seven_seg_scan
// PURPOSE
//  Display-side reader for a held N-bit board value: time-multiplexes it onto a
//  common-anode 7-segment bank as hex digits, one digit lit at a time.
//  Sits between the switch/LED capture register output and the board's an/seg pins.
//  It freezes its own snapshot under `retain`, matching the capture register's hold semantics.
// PARAMETERS
//  N            8        width of displayed value; multiple of 4; DIGITS = N/4 (localparam)
//  REFRESH_DIV  100000   clk cycles each digit stays lit; >= 2
// PORTS
//  clk      in   1          system clock, all logic on rising edge
//  reset    in   1          synchronous, active-high
//  value    in   N          value to display, nibble k -> digit k (digit 0 = rightmost)
//  retain   in   1          1: keep current snapshot; 0: reload snapshot at frame boundary
//  an       out  DIGITS     digit enables, active-low, at most one low per cycle
//  seg      out  7          segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  - State: prescaler cnt [0..REFRESH_DIV-1], digit index idx [0..DIGITS-1], snapshot [N].
//  - Reset (sync): cnt=0, idx=0, snapshot=0, an=all 1s, seg=7'h7F (all dark).
//    Reset asserted mid-scan takes effect the next edge regardless of cnt/idx.
//  - cnt increments every cycle; at cnt==REFRESH_DIV-1 cnt->0 and idx advances;
//    idx==DIGITS-1 wraps to 0.
//  - Frame boundary = cycle where cnt==REFRESH_DIV-1 and idx==DIGITS-1. On that edge,
//    if retain==0 snapshot<=value; if retain==1 snapshot unchanged. value is
//    sampled only there (no tearing within a frame).
//  - an/seg are registered from the current (pre-edge) idx/snapshot: one-cycle latency.
//    First cycle after reset release: an = ~(1<<0), seg = font(snapshot[3:0]) = 7'h40.
//  - Each digit lit for exactly REFRESH_DIV cycles; full frame = DIGITS*REFRESH_DIV.
//  - Font (active-low hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//    8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
//  - retain toggling mid-frame: only its value on the frame-boundary edge matters.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digits above the highest nonzero snapshot nibble
//    are blanked (an bit stays 1, seg=7'h7F) during their slot; digit 0 always lit;
//    slot timing unchanged.
//  Not defined: every digit is lit, leading zeros shown as 7'h40.
// STRUCTURE
//  - seg_pkg: SEG_BLANK = 7'h7F constant, seg_t typedef (logic [6:0]), 16-entry
//    font table as a constant array.
//  - Sub-module hex_to_7seg (combinational nibble -> seg_t lookup via seg_pkg);
//    seven_seg_scan holds prescaler, idx, snapshot and output registers.
// TESTING  (N=8, REFRESH_DIV=4 unless noted)
//  1 reset held 3 cycles -> an=2'b11, seg=7'h7F; first cycle after release
//    an=2'b10, seg=7'h40.
//  2 value=8'hA5, retain=0 -> after first boundary: an=2'b10, seg=7'h12 for 4
//    cycles, then an=2'b01, seg=7'h08 for 4 cycles, repeating.
//  3 after 2, retain=1, value=8'h3C -> A5 held for 3 frames; retain=0 -> 3C shown
//    from the cycle after the next boundary (7'h46 on digit 0, 7'h30 on digit 1).
//  4 reset pulsed while idx=1, cnt=2 -> next cycle an=2'b11, seg=7'h7F; scan
//    restarts at digit 0, snapshot=0.
//  5 value=8'h07 with LEADING_ZERO_BLANK_EN -> digit-1 slot an=2'b11, seg=7'h7F;
//    without macro -> an=2'b01, seg=7'h40.
//  6 N=16 -> an cycles 1110,1101,1011,0111,1110, 4 cycles each; wrap 3->0 has no gap.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment types and the active-low hex font used by the display scanner.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, active-low, common-anode wiring.
  localparam seg_t FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  assign seg_o = FONT[nibble_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display driver for a common-anode 7-segment bank.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the highest nonzero nibble.
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   value,
  input  logic           retain,
  output logic [N/4-1:0] an,
  output logic [6:0]     seg
);

  localparam int unsigned DIGITS = N / 4;
  localparam int unsigned CntW   = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [N-1:0]      snap_q, snap_d;
  logic [DIGITS-1:0] an_q, an_d;
  seg_t              seg_q, seg_d;

  logic       cnt_last, idx_last;
  logic [3:0] cur_nibble;
  seg_t       cur_glyph;
  logic       blank;

  assign cnt_last = (cnt_q == CntW'(REFRESH_DIV - 1));
  assign idx_last = (idx_q == IdxW'(DIGITS - 1));

  always_comb begin
    cnt_d  = cnt_last ? '0 : cnt_q + CntW'(1);
    idx_d  = idx_q;
    snap_d = snap_q;
    if (cnt_last) begin
      idx_d = idx_last ? '0 : idx_q + IdxW'(1);
      // Snapshot only reloads at the frame boundary so a frame never tears.
      if (idx_last && !retain) begin
        snap_d = value;
      end
    end
  end

  always_comb begin
    cur_nibble = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_nibble = snap_q[k*4 +: 4];
      end
    end
  end

  hex_to_7seg u_font (
    .nibble_i (cur_nibble),
    .seg_o    (cur_glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Blank when this digit and every digit above it are zero; digit 0 is never blanked.
  always_comb begin
    blank = (idx_q != '0);
    for (int k = 0; k < DIGITS; k++) begin
      if ((IdxW'(k) >= idx_q) && (snap_q[k*4 +: 4] != 4'h0)) begin
        blank = 1'b0;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (!blank) begin
      seg_d = cur_glyph;
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_q == IdxW'(k)) begin
          an_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
